// File: rtl/lcd_bus_driver.sv
// Queues CPU LCD-register stores and replays them as HD44780 write cycles (RS/DATA setup, EN pulse, hold, exec wait).
// A store into an idle, empty driver bypasses the FIFO so that the pins update on the next cycle.
module lcd_bus_driver #(
  parameter int FIFO_DEPTH  = 4,
  parameter int T_SETUP     = 2,
  parameter int T_PULSE     = 12,
  parameter int T_HOLD      = 2,
  parameter int T_EXEC      = 2000,
  parameter int T_EXEC_LONG = 82000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wr_en,
  input  logic [31:0] i_wr_data,
  input  logic        i_ovf_clr,
  output logic [31:0] o_status,
  output logic        o_busy,
  output logic        o_lcd_on,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic [7:0]  o_lcd_data,
  output logic [31:0] o_io_lcd
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [16:0] C_SETUP     = 17'(T_SETUP - 1);
  localparam logic [16:0] C_PULSE     = 17'(T_PULSE - 1);
  localparam logic [16:0] C_HOLD      = 17'(T_HOLD - 1);
  localparam logic [16:0] C_EXEC      = 17'(T_EXEC - 1);
  localparam logic [16:0] C_EXEC_LONG = 17'(T_EXEC_LONG - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT
  } state_t;

  state_t      state, state_nxt;
  logic [16:0] cnt, cnt_nxt;

  // Only {on, rs, data} of a store matter, so that is all the FIFO keeps.
  logic [9:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [9:0]  in_word, src;
  logic        empty, full, load, bypass, pop, push, overflow, long_cmd, busy_nxt;
  logic        rs, on, ovf, busy;
  logic [7:0]  data;
  logic        unused_wr_bits;

  assign in_word        = {i_wr_data[31], i_wr_data[9], i_wr_data[7:0]};
  assign unused_wr_bits = ^{i_wr_data[30:10], i_wr_data[8]};

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign load     = (state == S_IDLE) && (!empty || i_wr_en);
  assign bypass   = (state == S_IDLE) && empty && i_wr_en;
  assign pop      = load && !empty;
  assign src      = empty ? in_word : mem[rd_ptr[AW-1:0]];
  assign push     = i_wr_en && !bypass && (!full || pop);
  assign overflow = i_wr_en && full && !pop;

  // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
  assign long_cmd = !rs && (data[7:2] == 6'd0) && (data != 8'd0);

  assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, push};
  assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (load) begin
          state_nxt = S_SETUP;
          cnt_nxt   = C_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt == 17'd0) begin
          state_nxt = S_PULSE;
          cnt_nxt   = C_PULSE;
        end else begin
          cnt_nxt = cnt - 17'd1;
        end
      end
      S_PULSE: begin
        if (cnt == 17'd0) begin
          state_nxt = S_HOLD;
          cnt_nxt   = C_HOLD;
        end else begin
          cnt_nxt = cnt - 17'd1;
        end
      end
      S_HOLD: begin
        if (cnt == 17'd0) begin
          state_nxt = S_WAIT;
          cnt_nxt   = long_cmd ? C_EXEC_LONG : C_EXEC;
        end else begin
          cnt_nxt = cnt - 17'd1;
        end
      end
      S_WAIT: begin
        if (cnt == 17'd0) begin
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt - 17'd1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 17'd0;
      end
    endcase
  end

  assign busy_nxt = (state_nxt != S_IDLE) || (wr_ptr_nxt != rd_ptr_nxt);

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_word;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state  <= S_IDLE;
      cnt    <= 17'd0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      rs     <= 1'b0;
      on     <= 1'b0;
      data   <= 8'd0;
      ovf    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      busy   <= busy_nxt;
      if (load) begin
        on   <= src[9];
        rs   <= src[8];
        data <= src[7:0];
      end
      if (overflow)       ovf <= 1'b1;
      else if (i_ovf_clr) ovf <= 1'b0;
    end
  end

  assign o_lcd_en   = (state == S_PULSE);
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_rs   = rs;
  assign o_lcd_on   = on;
  assign o_lcd_data = data;
  assign o_busy     = busy;
  assign o_status   = {29'd0, ovf, full, busy};
  assign o_io_lcd   = {on, 20'd0, o_lcd_en, rs, 1'b0, data};

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Directed bench for lcd_bus_driver: a transaction-level timing model checked every cycle, plus literal pin checks.
module tb_lcd_bus_driver;

  localparam int DEPTH = 4;
  localparam int TS    = 2;
  localparam int TP    = 4;
  localparam int TH    = 2;
  localparam int TE    = 10;
  localparam int TEL   = 30;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = 32'd0;
  logic        ovf_clr = 1'b0;
  logic [31:0] status, io_lcd;
  logic        busy, lcd_on, lcd_rs, lcd_rw, lcd_en;
  logic [7:0]  lcd_data;

  int vectors = 0;
  int miscompares = 0;

  lcd_bus_driver #(
    .FIFO_DEPTH(DEPTH), .T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH),
    .T_EXEC(TE), .T_EXEC_LONG(TEL)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_data(wr_data),
    .i_ovf_clr(ovf_clr), .o_status(status), .o_busy(busy), .o_lcd_on(lcd_on),
    .o_lcd_rs(lcd_rs), .o_lcd_rw(lcd_rw), .o_lcd_en(lcd_en), .o_lcd_data(lcd_data),
    .o_io_lcd(io_lcd)
  );

  always #5 clk = ~clk;

  // Model: each transfer is a span of TS+TP+TH+exec cycles starting the cycle after its pop.
  logic [31:0] mq[$];
  bit          m_started = 0;
  bit          m_active = 0;
  int          m_t = 0;
  int          m_dur = 0;
  bit          m_rs = 0, m_on = 0, m_ovf = 0, m_busy = 0;
  logic [7:0]  m_data = 8'd0;
  bit          idle_now, took;
  int          sz_before;
  logic [31:0] w;

  always @(posedge clk) begin
    m_started = 1;
    if (!rst_n) begin
      mq.delete();
      m_active = 0; m_t = 0; m_dur = 0;
      m_rs = 0; m_on = 0; m_ovf = 0; m_busy = 0; m_data = 8'd0;
    end else begin
      idle_now  = !m_active;
      sz_before = mq.size();
      took      = 0;
      if (!idle_now) begin
        m_t++;
        if (m_t == m_dur) m_active = 0;
      end
      if (idle_now && (sz_before > 0 || wr_en)) begin
        if (sz_before > 0) w = mq.pop_front();
        else begin
          w = wr_data;
          took = 1;
        end
        m_on = w[31]; m_rs = w[9]; m_data = w[7:0];
        m_active = 1; m_t = 0;
        m_dur = TS + TP + TH +
                ((!w[9] && w[7:0] >= 8'd1 && w[7:0] <= 8'd3) ? TEL : TE);
      end
      if (wr_en && !took) begin
        if (sz_before < DEPTH || (idle_now && sz_before > 0)) mq.push_back(wr_data);
        else m_ovf = 1;
      end else if (ovf_clr) begin
        m_ovf = 0;
      end
      if (wr_en && !took && !(sz_before < DEPTH || (idle_now && sz_before > 0))) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      m_busy = m_active || (mq.size() > 0);
    end
  end

  logic [76:0] got_v, exp_v;
  bit          exp_en;
  always @(negedge clk) begin
    if (m_started) begin
      exp_en = m_active && (m_t >= TS) && (m_t < TS + TP);
      exp_v = {29'd0, m_ovf, (mq.size() == DEPTH), m_busy,
               m_on, 20'd0, exp_en, m_rs, 1'b0, m_data,
               m_busy, m_on, m_rs, 1'b0, exp_en, m_data};
      got_v = {status, io_lcd, busy, lcd_on, lcd_rs, lcd_rw, lcd_en, lcd_data};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL cycle_model @%0t: got %h expected %h", $time, got_v, exp_v);
      end
    end
  end

  // Data byte seen at each rising edge of EN, in order.
  logic [7:0] cap[$];
  bit prev_en = 0;
  always @(negedge clk) begin
    if (lcd_en === 1'b1 && !prev_en) cap.push_back(lcd_data);
    prev_en = (lcd_en === 1'b1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      tick();
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic put(input logic [31:0] d);
    wr_en = 1'b1;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    tick_n(2);
    check("reset_io", io_lcd, 32'd0);
    check("reset_status", status, 32'd0);
    rst_n = 1'b1;

    // 1: normal data write, write at cycle 0
    put(32'h8000_0241);                                   // cycle 1
    check("t1_on_rs_data", {22'd0, lcd_on, lcd_rs, lcd_data}, 32'h341);
    check("t1_busy_c1", {31'd0, busy}, 32'd1);
    tick();                                               // cycle 2
    check("t1_en_c2", {31'd0, lcd_en}, 32'd0);
    tick();                                               // cycle 3
    check("t1_en_c3", {31'd0, lcd_en}, 32'd1);
    tick_n(3);                                            // cycle 6
    check("t1_en_c6", {31'd0, lcd_en}, 32'd1);
    tick();                                               // cycle 7
    check("t1_en_c7", {31'd0, lcd_en}, 32'd0);
    tick_n(11);                                           // cycle 18
    check("t1_busy_c18", {31'd0, busy}, 32'd1);
    tick();                                               // cycle 19
    check("t1_busy_c19", {31'd0, busy}, 32'd0);

    // 2: clear display uses the long wait
    put(32'h0000_0001);                                   // cycle 1
    check("t2_io_setup", io_lcd, 32'h0000_0001);
    tick_n(37);                                           // cycle 38
    check("t2_busy_c38", {31'd0, busy}, 32'd1);
    tick();                                               // cycle 39
    check("t2_busy_c39", {31'd0, busy}, 32'd0);

    // 3: one transfer in flight, then five back-to-back stores
    cap.delete();
    put(32'h0000_0241);
    for (int i = 0; i < 5; i++) put(32'h0000_0200 + i);   // stores at cycles 1..5
    check("t3_ovf_full", status & 32'h6, 32'h6);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t3_ovf_cleared", status & 32'h4, 32'd0);
    wait_idle("t3_drain");
    check("t3_count", cap.size(), 5);
    if (cap.size() == 5) begin
      check("t3_order0", {24'd0, cap[0]}, 32'h41);
      check("t3_order4", {24'd0, cap[4]}, 32'h03);
    end

    // 4: store on the same cycle IDLE pops a full FIFO
    cap.delete();
    put(32'h0000_0210);                                   // cycle 1
    for (int i = 1; i < 5; i++) put(32'h0000_0210 + i);   // cycle 5
    tick_n(14);                                           // cycle 19
    check("t4_full_at_pop", status & 32'h2, 32'h2);
    put(32'h0000_0215);
    check("t4_no_ovf", status & 32'h4, 32'd0);
    wait_idle("t4_drain");
    check("t4_count", cap.size(), 6);
    for (int i = 0; i < 6 && i < cap.size(); i++)
      check("t4_order", {24'd0, cap[i]}, 32'h10 + i);

    // 5: reset during the EN pulse
    put(32'h8000_0241);                                   // cycle 1
    put(32'h0000_0242);                                   // cycle 2
    tick_n(2);                                            // cycle 4
    check("t5_en_before", {31'd0, lcd_en}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t5_en", {31'd0, lcd_en}, 32'd0);
    check("t5_io", io_lcd, 32'd0);
    check("t5_status", status, 32'd0);
    tick_n(3);
    check("t5_flushed", {31'd0, busy}, 32'd0);

    // 6: overflow and clear in the same cycle
    put(32'h0000_0241);
    for (int i = 0; i < 4; i++) put(32'h0000_0230 + i);
    ovf_clr = 1'b1;
    put(32'h0000_0240);
    ovf_clr = 1'b0;
    check("t6_set_wins", status & 32'h4, 32'h4);
    wait_idle("t6_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
